// File: rtl/bus_fifo_reader.sv
// Unpacks IN_DEPTH-beat words from a show-ahead FIFO into a WIDTH-bit valid/ready beat stream.
// Optional: define BUS_FIFO_READER_LAST_EN to add out_last on the final beat of each word.
module bus_fifo_reader #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned IN_DEPTH = 6,
  localparam int unsigned IDX_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      fifo_empty,
  input  logic [IN_DEPTH*WIDTH-1:0] fifo_rd_data,
  output logic                      fifo_rd_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx
`ifdef BUS_FIFO_READER_LAST_EN
  ,
  output logic                      out_last
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_held [IN_DEPTH];
  logic             w_load;
  logic             w_last;
  logic             w_xfer;
  logic             w_can_pop;

  assign w_last    = (r_cnt == IDX_W'(IN_DEPTH - 1));
  assign w_xfer    = (r_state == STREAM) && out_ready;
  // Pop is also masked while reset is asserted so the strobe reads 0 during reset.
  assign w_can_pop = rstn && en && !fifo_empty && !flush;

  // Next-state: flush wins over everything, last-beat transfer may reload with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_pop) begin
            w_load      = 1'b1;
            w_state_nxt = STREAM;
            w_cnt_nxt   = '0;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            if (!w_last) begin
              w_cnt_nxt = IDX_W'(r_cnt + 1'b1);
            end else if (w_can_pop) begin
              w_load    = 1'b1;
              w_cnt_nxt = '0;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < int'(IN_DEPTH); i++) begin
        r_held[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        for (int i = 0; i < int'(IN_DEPTH); i++) begin
          r_held[i] <= fifo_rd_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign fifo_rd_en = w_load;
  assign out_valid  = (r_state == STREAM);
  assign out_data   = r_held[r_cnt];
  assign out_idx    = r_cnt;

`ifdef BUS_FIFO_READER_LAST_EN
  assign out_last = out_valid && w_last;
`endif

endmodule

// File: tb/tb_bus_fifo_reader.sv
// Randomized and directed bench for bus_fifo_reader against a queue-of-beats reference model.
// Optional: define BUS_FIFO_READER_LAST_EN to also check out_last.
module tb_bus_fifo_reader;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WORD_W = WIDTH * DEPTH;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [WORD_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_en;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic [IDX_W-1:0]  out_idx;
`ifdef BUS_FIFO_READER_LAST_EN
  logic              out_last;
`endif

  always #5 clk = ~clk;

  bus_fifo_reader #(.WIDTH(WIDTH), .IN_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
`ifdef BUS_FIFO_READER_LAST_EN
    , .out_last(out_last)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: upstream FIFO contents and the beats still owed downstream.
  logic [WORD_W-1:0] q_fifo[$];
  logic [WIDTH-1:0]  q_data[$];
  int                q_idx[$];

  logic              exp_pop;
  logic              exp_valid;
  logic [WIDTH-1:0]  exp_data;
  int                exp_idx;
  logic              exp_last;

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < int'(DEPTH); i++) w[i*WIDTH +: WIDTH] = $urandom;
    return w;
  endfunction

  // Drive one cycle's inputs at the falling edge and derive the expected outputs.
  task automatic cycle_begin(input logic e, input logic f, input logic r);
    @(negedge clk);
    en         = e;
    flush      = f;
    out_ready  = r;
    fifo_empty = (q_fifo.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : q_fifo[0];
    exp_valid  = (q_data.size() > 0);
    exp_data   = exp_valid ? q_data[0] : '0;
    exp_idx    = exp_valid ? q_idx[0] : 0;
    exp_last   = exp_valid && (exp_idx == int'(DEPTH) - 1);
    exp_pop    = rstn && e && !f && !fifo_empty &&
                 ((q_data.size() == 0) || (r && q_data.size() == 1));
    #1;
  endtask

  // Advance the model to what the coming rising edge should produce.
  task automatic cycle_end();
    logic [WORD_W-1:0] w;
    if (flush) begin
      q_data.delete();
      q_idx.delete();
    end else begin
      if (out_ready && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
      end
      if (exp_pop) begin
        w = q_fifo.pop_front();
        for (int i = 0; i < int'(DEPTH); i++) begin
          q_data.push_back(w[i*WIDTH +: WIDTH]);
          q_idx.push_back(i);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q_data.size() > 0 || q_fifo.size() > 0); i++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      cycle_end();
    end
    cycle_begin(1'b0, 1'b0, 1'b1);
    cycle_end();
  endtask

  task automatic test_reset();
    q_fifo.push_back(rand_word());
    cycle_begin(1'b1, 1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL rst_data: got %0h exp 0", out_data); else n_pass++;
    n_total++; if (out_idx !== '0) $display("FAIL rst_idx: got %0d exp 0", out_idx); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b exp 0", fifo_rd_en); else n_pass++;
`ifdef BUS_FIFO_READER_LAST_EN
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b exp 0", out_last); else n_pass++;
`endif
    q_fifo.delete();
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_word();
    logic [WORD_W-1:0] w;
    int pops = 0;
    int beat = 0;
    for (int i = 0; i < int'(DEPTH); i++) w[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    q_fifo.push_back(w);
    for (int c = 0; c < 9; c++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL sw_rd_en c%0d: got %b exp %b", c, fifo_rd_en, exp_pop); else n_pass++;
      n_total++; if (out_valid !== exp_valid) $display("FAIL sw_valid c%0d: got %b exp %b", c, out_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (out_data !== WIDTH'(beat + 1)) $display("FAIL sw_data c%0d: got %0d exp %0d", c, out_data, beat + 1); else n_pass++;
        n_total++; if (out_idx !== IDX_W'(beat)) $display("FAIL sw_idx c%0d: got %0d exp %0d", c, out_idx, beat); else n_pass++;
        beat++;
      end
      if (fifo_rd_en) pops++;
      cycle_end();
    end
    n_total++; if (pops != 1) $display("FAIL sw_pops: got %0d exp 1", pops); else n_pass++;
    n_total++; if (beat != int'(DEPTH)) $display("FAIL sw_beats: got %0d exp %0d", beat, DEPTH); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    int run = 0;
    int best = 0;
    for (int k = 0; k < 3; k++) q_fifo.push_back(rand_word());
    for (int c = 0; c < 24; c++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL b2b_rd_en c%0d: got %b exp %b", c, fifo_rd_en, exp_pop); else n_pass++;
      n_total++; if (out_valid !== exp_valid) $display("FAIL b2b_valid c%0d: got %b exp %b", c, out_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (out_data !== exp_data || out_idx !== IDX_W'(exp_idx))
          $display("FAIL b2b_beat c%0d: got %0h/%0d exp %0h/%0d", c, out_data, out_idx, exp_data, exp_idx); else n_pass++;
      end
      if (fifo_rd_en && pops > 0) begin
        n_total++; if (!(out_valid === 1'b1 && out_idx === IDX_W'(DEPTH - 1)))
          $display("FAIL b2b_reload_align c%0d: got valid %b idx %0d exp 1/%0d", c, out_valid, out_idx, DEPTH - 1); else n_pass++;
      end
      if (fifo_rd_en) pops++;
      run  = out_valid ? run + 1 : 0;
      best = (run > best) ? run : best;
      cycle_end();
    end
    n_total++; if (pops != 3) $display("FAIL b2b_pops: got %0d exp 3", pops); else n_pass++;
    n_total++; if (best != 18) $display("FAIL b2b_run: got %0d exp 18", best); else n_pass++;
  endtask

  task automatic test_backpressure();
    int stall = 0;
    logic [WIDTH-1:0] frozen;
    q_fifo.push_back(rand_word());
    q_fifo.push_back(rand_word());
    for (int c = 0; c < 30; c++) begin
      logic r;
      r = !(q_idx.size() > 0 && q_idx[0] == 2 && stall < 4 && q_fifo.size() == 1);
      cycle_begin(1'b1, 1'b0, r);
      n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL bp_rd_en c%0d: got %b exp %b", c, fifo_rd_en, exp_pop); else n_pass++;
      n_total++; if (out_valid !== exp_valid) $display("FAIL bp_valid c%0d: got %b exp %b", c, out_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (out_data !== exp_data || out_idx !== IDX_W'(exp_idx))
          $display("FAIL bp_beat c%0d: got %0h/%0d exp %0h/%0d", c, out_data, out_idx, exp_data, exp_idx); else n_pass++;
      end
      if (!r) begin
        if (stall == 0) frozen = exp_data;
        n_total++; if (out_idx !== 3'd2 || out_data !== frozen || fifo_rd_en !== 1'b0)
          $display("FAIL bp_frozen s%0d: got idx %0d data %0h rd %b exp 2/%0h/0", stall, out_idx, out_data, fifo_rd_en, frozen); else n_pass++;
        stall++;
      end
      cycle_end();
    end
    n_total++; if (stall != 4) $display("FAIL bp_stalls: got %0d exp 4", stall); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    logic [WORD_W-1:0] w2;
    w2 = rand_word();
    q_fifo.push_back(rand_word());
    q_fifo.push_back(w2);
    for (int c = 0; c < 10 && !(q_idx.size() > 0 && q_idx[0] == 3); c++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      cycle_end();
    end
    cycle_begin(1'b1, 1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b1 || out_idx !== 3'd3) $display("FAIL fl_pre: got %b/%0d exp 1/3", out_valid, out_idx); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL fl_no_pop: got %b exp 0", fifo_rd_en); else n_pass++;
    cycle_end();
    cycle_begin(1'b1, 1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL fl_valid: got %b exp 0", out_valid); else n_pass++;
    n_total++; if (fifo_rd_en !== 1'b1 || exp_pop !== 1'b1) $display("FAIL fl_repop: got %b exp 1", fifo_rd_en); else n_pass++;
    cycle_end();
    cycle_begin(1'b1, 1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== w2[WIDTH-1:0])
      $display("FAIL fl_resume: got %b/%0d/%0h exp 1/0/%0h", out_valid, out_idx, out_data, w2[WIDTH-1:0]); else n_pass++;
    cycle_end();
    drain();
  endtask

  task automatic test_reset_mid();
    q_fifo.push_back(rand_word());
    q_fifo.push_back(rand_word());
    for (int c = 0; c < 10 && !(q_idx.size() > 0 && q_idx[0] == 4); c++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      cycle_end();
    end
    cycle_begin(1'b1, 1'b0, 1'b1);
    n_total++; if (out_idx !== 3'd4) $display("FAIL rm_pre: got %0d exp 4", out_idx); else n_pass++;
    en   = 1'b0;
    rstn = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 || fifo_rd_en !== 1'b0)
      $display("FAIL rm_async: got %b/%0h/%0d/%b exp all 0", out_valid, out_data, out_idx, fifo_rd_en); else n_pass++;
    q_data.delete();
    q_idx.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle_begin(1'b0, 1'b0, 1'b1);
      n_total++; if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL rm_idle c%0d: got rd %b valid %b exp 0/0", c, fifo_rd_en, out_valid); else n_pass++;
      cycle_end();
    end
    cycle_begin(1'b1, 1'b0, 1'b1);
    n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL rm_resume: got %b exp %b", fifo_rd_en, exp_pop); else n_pass++;
    cycle_end();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic e, f, r;
      if (q_fifo.size() < 4 && $urandom_range(0, 9) < 4) q_fifo.push_back(rand_word());
      e = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 49) == 0);
      cycle_begin(e, f, r);
      n_total++; if (fifo_rd_en !== exp_pop) $display("FAIL rnd_rd_en c%0d: got %b exp %b", c, fifo_rd_en, exp_pop); else n_pass++;
      n_total++; if (out_valid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b exp %b", c, out_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (out_data !== exp_data || out_idx !== IDX_W'(exp_idx))
          $display("FAIL rnd_beat c%0d: got %0h/%0d exp %0h/%0d", c, out_data, out_idx, exp_data, exp_idx); else n_pass++;
      end
`ifdef BUS_FIFO_READER_LAST_EN
      n_total++; if (out_last !== exp_last) $display("FAIL rnd_last c%0d: got %b exp %b", c, out_last, exp_last); else n_pass++;
`endif
      cycle_end();
    end
    drain();
  endtask

`ifdef BUS_FIFO_READER_LAST_EN
  task automatic test_last();
    int lasts = 0;
    q_fifo.push_back(rand_word());
    q_fifo.push_back(rand_word());
    for (int c = 0; c < 16; c++) begin
      cycle_begin(1'b1, 1'b0, 1'b1);
      n_total++; if (out_last !== exp_last) $display("FAIL last c%0d: got %b exp %b", c, out_last, exp_last); else n_pass++;
      if (out_last && out_idx === IDX_W'(DEPTH - 1)) lasts++;
      cycle_end();
    end
    n_total++; if (lasts != 2) $display("FAIL last_count: got %0d exp 2", lasts); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef BUS_FIFO_READER_LAST_EN
    test_last();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_fifo_reader.md
BUS_FIFO_READER -- requirements
Module: bus_fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per output beat.
REQ-002 SHALL have parameter IN_DEPTH, default 6: beats per FIFO word.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  enables popping new words from the FIFO.
REQ-006 SHALL have port flush  input  1  synchronous discard of the held word.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data  input  IN_DEPTH x WIDTH  upstream head word, show-ahead (valid while fifo_empty=0).
REQ-009 SHALL have port fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-010 SHALL have port out_valid  output  1  beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_data  output  WIDTH  current beat.
REQ-013 SHALL have port out_idx  output  clog2(IN_DEPTH)  beat index in the word, 0..IN_DEPTH-1.

Function
REQ-014 SHALL implement FSM states IDLE (no word held) and STREAM (word held in an IN_DEPTH x WIDTH register, beat counter cnt).
REQ-015 In IDLE, SHALL drive fifo_rd_en=1 combinationally iff en=1, fifo_empty=0 and flush=0; on that edge it captures fifo_rd_data, sets cnt=0 and enters STREAM.
REQ-016 SHALL drive out_valid=1 only in STREAM, with out_data=held[cnt] and out_idx=cnt; all three are registered/held values, never combinational from fifo_rd_data.
REQ-017 First beat SHALL appear 1 cycle after the fifo_rd_en cycle; beats SHALL be emitted in index order 0 first.
REQ-018 A beat SHALL transfer only on out_valid=1 and out_ready=1; with out_ready=0, out_data/out_idx SHALL hold stable.
REQ-019 On transfer with cnt<IN_DEPTH-1, cnt SHALL increment by 1.
REQ-020 On transfer with cnt=IN_DEPTH-1: if en=1 and fifo_empty=0, SHALL assert fifo_rd_en that cycle, reload the word, set cnt=0 and remain in STREAM (no bubble); else enter IDLE.
REQ-021 Sustained throughput SHALL be 1 beat/cycle with out_ready held 1 and FIFO non-empty.
REQ-022 fifo_rd_en SHALL pulse at most once per word and never while fifo_empty=1.
REQ-023 flush=1 SHALL force IDLE, cnt=0, out_valid=0 on the next edge, suppress fifo_rd_en that cycle, and override any same-cycle transfer/reload.
REQ-024 en=0 SHALL NOT stop the held word from draining; it only blocks new pops.

Reset
REQ-025 rstn=0 SHALL asynchronously force IDLE, cnt=0, held word=0, out_valid=0, out_data=0, out_idx=0, fifo_rd_en=0.
REQ-026 Reset mid-word SHALL discard remaining beats; no pop SHALL occur in the first cycle after deassertion unless REQ-015 conditions hold.

Configuration
REQ-027 With macro BUS_FIFO_READER_LAST_EN defined, SHALL add output out_last (1 bit) = out_valid and cnt=IN_DEPTH-1, reset 0.
REQ-028 Without BUS_FIFO_READER_LAST_EN, out_last SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029 Single word: FIFO holds word {6,5,4,3,2,1}(idx5..0), en=1, out_ready=1 -> fifo_rd_en 1 cycle, then out_data 1,2,3,4,5,6 on 6 consecutive cycles, out_idx 0..5, then IDLE.
REQ-030 Back-to-back: 3 words queued, out_ready=1 -> 18 consecutive valid beats, exactly 3 fifo_rd_en pulses, each coincident with the idx-5 transfer (except the first).
REQ-031 Backpressure: out_ready=0 for 4 cycles at idx 2 -> out_data/out_idx frozen at idx 2, no fifo_rd_en, resumes at idx 3.
REQ-032 Flush at idx 3 with FIFO non-empty -> out_valid=0 next cycle, no pop that cycle, next word popped the following cycle starting idx 0.
REQ-033 Reset asserted at idx 4 -> all outputs 0 immediately; after release with en=0 no fifo_rd_en.
REQ-034 BUS_FIFO_READER_LAST_EN defined, two words streamed -> out_last=1 exactly on the two idx-5 beats.
